mstq_arbiter: RTL and testbench
===============================

# mstq_arbiter

Packet-atomic round-robin arbiter that merges two requester queues (server engine and a second DMA/requester engine) into the single 18-bit master-bus write queue drained by the TLP engine. Sits in the `pcie_clk` domain between requester FWFT FIFOs and the master-queue FIFO write port. Per-packet grant, one-word output register, per-source packet counters and sticky framing-error flags for the slave register map.

## Interface
Parameters:
- `CNT_W`, 16, width of per-source packet counters.

Ports:
- `pcie_clk` in 1: sole clock.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `en` in 1: arbitration enable; sampled only at packet boundaries.
- `s0_dout` in 18: source 0 word; `[17]`=SOF, `[16]`=EOF, `[15:0]`=data; FWFT (valid while `!s0_empty`).
- `s0_empty` in 1: source 0 empty.
- `s0_rd_en` out 1: pop source 0.
- `s1_dout`, `s1_empty`, `s1_rd_en`: same for source 1.
- `mst_din` out 18: word to master queue.
- `mst_wr_en` out 1: write strobe; never asserted while `mst_full`.
- `mst_full` in 1: master queue full.
- `grant` out 2: one-hot current owner; `2'b00` when idle.
- `pkt_cnt0`, `pkt_cnt1` out CNT_W: packets forwarded per source.
- `err` out 2: sticky framing error per source.
- `err_clr` in 1: clears `err`.

## Operation
- States: IDLE, XFER.
- IDLE: if `en` and any source non-empty, grant per round robin. `last` bit holds last-granted source; the other source has priority. Only one requester → grant it. Enter XFER the next cycle. `last` updates on grant.
- XFER: `sK_rd_en = !sK_empty & (!ovalid | !mst_full)` for the granted K only; popped word loads output register `oreg`, `ovalid` set.
- Popping a word with EOF=1 → IDLE next cycle; `pkt_cntK` increments (wraps at 2^CNT_W).
- Granted source empties mid-packet: hold grant, wait indefinitely; no other source served.
- `en` deasserted mid-packet: packet completes; no new grant.
- Framing: first word of a grant without SOF, or SOF inside a packet → `err[K]` set. Word is still forwarded unchanged. An SOF+EOF word is a legal 1-word packet.
- `err_clr` with simultaneous new error: error wins (bit stays set).
- Output: `mst_wr_en = ovalid & !mst_full`; `mst_din = oreg`. `ovalid` clears on write unless a new pop loads the register in the same cycle.

## Timing
- Reset: state IDLE, `last`=1 (source 0 first), `grant`=0, `ovalid`=0, `mst_wr_en`=0, `mst_din`=0, `s*_rd_en`=0, counters=0, `err`=0.
- `sK_rd_en`, `mst_wr_en` combinational from registered state and inputs. `grant`, counters and `err` are registered.
- Grant latency: request visible in IDLE at cycle t → `grant` at t+1 → first pop at t+1 (if `!mst_full` or `!ovalid`) → `mst_wr_en` at t+2.
- Throughput: 1 word/cycle sustained while granted source is non-empty and `mst_full` is low.
- Packet gap: 1 idle cycle (IDLE state) between packets on the bus, independent of the next source.
- `mst_full` rising with `ovalid`=1: pop stalls the same cycle; no word lost or duplicated.
- Reset mid-packet: partial packet abandoned; no recovery framing is emitted (downstream FIFO is also reset by `sys_rst`).

## Structure
- Shared package: `MSTQ_W`=18, `MSTQ_SOF`=17, `MSTQ_EOF`=16 bit indices, so server, arbiter and TLP engine agree on framing.
- Single module, no sub-module. The 2-way round-robin choice is small enough to inline.

## Test plan
- Reset, then s0 pushes a 3-word packet (0x20000+0xA1, 0xA2, 0x10000+0xA3) → `mst_din` sequence identical on 3 consecutive `mst_wr_en` cycles starting 2 cycles after the push becomes visible; `pkt_cnt0`=1.
- s0 and s1 both hold 2 packets each from reset → order s0, s1, s0, s1 with no interleaving inside packets; `pkt_cnt0`=`pkt_cnt1`=2.
- `mst_full` toggled randomly during a 16-word packet → exactly 16 writes, in order, none while full.
- s1 empties after word 2 of 4 for 10 cycles while s0 is non-empty → no s0 pop until s1 delivers EOF.
- s0 packet missing SOF → `err`=2'b01, data forwarded; `err_clr` pulse → `err`=0; `en`=0 after grant → current packet completes, `grant` stays 0 afterward.
- `sys_rst` asserted mid-packet → all outputs at reset values in the same cycle (async); after release, next grant goes to s0.

Source files
------------

// File: rtl/mstq_arbiter_pkg.sv
// Shared master-queue framing definitions. The server, the arbiter and the TLP engine
// all use these so they agree on the word layout.
package mstq_arbiter_pkg;

    localparam int MSTQ_W   = 18;
    localparam int MSTQ_SOF = 17;
    localparam int MSTQ_EOF = 16;

    typedef logic [MSTQ_W-1:0] mstq_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } mstq_state_e;

endpackage

// File: rtl/mstq_arbiter.sv
// Packet-atomic two-way round-robin merge of requester FWFT queues into the master write queue.
// Provides a one-word output register, per-source packet counters and sticky framing errors.
module mstq_arbiter
    import mstq_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              pcie_clk,
    input  logic              sys_rst,
    input  logic              en,
    input  logic [MSTQ_W-1:0] s0_dout,
    input  logic              s0_empty,
    output logic              s0_rd_en,
    input  logic [MSTQ_W-1:0] s1_dout,
    input  logic              s1_empty,
    output logic              s1_rd_en,
    output logic [MSTQ_W-1:0] mst_din,
    output logic              mst_wr_en,
    input  logic              mst_full,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic [1:0]        err,
    input  logic              err_clr
);

    mstq_state_e      state_q;
    logic [1:0]       grant_q;
    logic             last_q;
    logic             first_q;
    mstq_word_t       oreg_q;
    logic             ovalid_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;
    logic [1:0]       err_q;
    logic [1:0]       err_d;

    logic       req0;
    logic       req1;
    logic       pick1;
    logic       src_empty;
    mstq_word_t src_word;
    logic       pop;
    logic       frame_bad;

    assign req0 = !s0_empty;
    assign req1 = !s1_empty;
    // last_q names the source granted most recently; the other one wins a tie
    assign pick1 = req1 && (!req0 || !last_q);

    assign src_empty = grant_q[0] ? s0_empty : s1_empty;
    assign src_word  = grant_q[0] ? s0_dout  : s1_dout;
    assign pop       = (state_q == ST_XFER) && !src_empty && (!ovalid_q || !mst_full);

    assign s0_rd_en  = pop && grant_q[0];
    assign s1_rd_en  = pop && grant_q[1];
    assign mst_wr_en = ovalid_q && !mst_full;
    assign mst_din   = oreg_q;
    assign grant     = grant_q;
    assign pkt_cnt0  = cnt0_q;
    assign pkt_cnt1  = cnt1_q;
    assign err       = err_q;

    // SOF must appear exactly on the first word of a grant; a new error beats err_clr
    assign frame_bad = pop && (first_q != src_word[MSTQ_SOF]);

    always_comb begin
        err_d = err_clr ? 2'b00 : err_q;
        if (frame_bad) begin
            err_d = err_d | grant_q;
        end
    end

    always_ff @(posedge pcie_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            first_q  <= 1'b0;
            oreg_q   <= '0;
            ovalid_q <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
            err_q    <= 2'b00;
        end else begin
            err_q <= err_d;

            if (pop) begin
                oreg_q   <= src_word;
                ovalid_q <= 1'b1;
            end else if (mst_wr_en) begin
                ovalid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (en && (req0 || req1)) begin
                        state_q <= ST_XFER;
                        grant_q <= pick1 ? 2'b10 : 2'b01;
                        last_q  <= pick1;
                        first_q <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (pop) begin
                        first_q <= 1'b0;
                        if (src_word[MSTQ_EOF]) begin
                            state_q <= ST_IDLE;
                            grant_q <= 2'b00;
                            if (grant_q[0]) begin
                                cnt0_q <= cnt0_q + CNT_W'(1);
                            end else begin
                                cnt1_q <= cnt1_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mstq_arbiter.sv
// Scoreboard bench for mstq_arbiter: packets are ordered at packet level by a round-robin
// model, and a monitor pops the expected words whenever the DUT writes.
module tb_mstq_arbiter;
    import mstq_arbiter_pkg::*;

    localparam int CNT_W = 16;

    logic              pcie_clk = 1'b0;
    logic              sys_rst;
    logic              en;
    logic [MSTQ_W-1:0] s0_dout;
    logic              s0_empty;
    logic              s0_rd_en;
    logic [MSTQ_W-1:0] s1_dout;
    logic              s1_empty;
    logic              s1_rd_en;
    logic [MSTQ_W-1:0] mst_din;
    logic              mst_wr_en;
    logic              mst_full;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  pkt_cnt0;
    logic [CNT_W-1:0]  pkt_cnt1;
    logic [1:0]        err;
    logic              err_clr;

    mstq_arbiter #(.CNT_W(CNT_W)) dut (
        .pcie_clk  (pcie_clk),
        .sys_rst   (sys_rst),
        .en        (en),
        .s0_dout   (s0_dout),
        .s0_empty  (s0_empty),
        .s0_rd_en  (s0_rd_en),
        .s1_dout   (s1_dout),
        .s1_empty  (s1_empty),
        .s1_rd_en  (s1_rd_en),
        .mst_din   (mst_din),
        .mst_wr_en (mst_wr_en),
        .mst_full  (mst_full),
        .grant     (grant),
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 pcie_clk = ~pcie_clk;

    // Source FIFO contents, staging areas, held-back words and the expected output stream
    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic [17:0] st0[$];
    logic [17:0] st1[$];
    logic [17:0] h1[$];
    logic [17:0] exp_q[$];

    int       checks = 0;
    int       errors = 0;
    int       wr_total = 0;
    bit       full_rand = 1'b0;
    int       hold1 = -1;
    bit       exp_last = 1'b1;
    bit [1:0] exp_err = 2'b00;
    int       exp_cnt0 = 0;
    int       exp_cnt1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end else begin
            $display("ok   %s value=%0h t=%0t", name, act, $time);
        end
    endtask

    // Source FIFO emulation and output monitor
    initial begin
        s0_dout  = '0;
        s1_dout  = '0;
        s0_empty = 1'b1;
        s1_empty = 1'b1;
        mst_full = 1'b0;
        forever begin
            @(negedge pcie_clk);
            s0_empty = (q0.size() == 0);
            s1_empty = (q1.size() == 0);
            s0_dout  = s0_empty ? 18'h0 : q0[0];
            s1_dout  = s1_empty ? 18'h0 : q1[0];
            mst_full = full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (!sys_rst) begin
                if (s0_rd_en && q0.size() > 0) void'(q0.pop_front());
                if (s1_rd_en && q1.size() > 0) void'(q1.pop_front());
                if (mst_wr_en) begin
                    wr_total++;
                    check("wr_while_full", 32'(mst_full), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=%0h required=none t=%0t", mst_din, $time);
                    end else begin
                        check("mst_din", 32'(mst_din), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic gen_pkt(input int src, input int len, input bit bad_sof);
        logic [17:0] w;
        for (int i = 0; i < len; i++) begin
            w = {(i == 0) && !bad_sof, i == len - 1, 16'($urandom)};
            if (src == 0) st0.push_back(w);
            else          st1.push_back(w);
        end
    endtask

    // Hand staged packets to the sources and predict framing, counts and packet order
    task automatic commit();
        bit          inpkt;
        bit          pick1;
        int          n;
        logic [17:0] w;
        for (int s = 0; s < 2; s++) begin
            inpkt = 1'b0;
            n = (s == 0) ? st0.size() : st1.size();
            for (int i = 0; i < n; i++) begin
                if (s == 0) w = st0[i];
                else        w = st1[i];
                if (inpkt == w[17]) exp_err[s] = 1'b1;
                if (w[16]) begin
                    inpkt = 1'b0;
                    if (s == 0) exp_cnt0++;
                    else        exp_cnt1++;
                end else begin
                    inpkt = 1'b1;
                end
                if (s == 0)                      q0.push_back(w);
                else if (hold1 >= 0 && i >= hold1) h1.push_back(w);
                else                              q1.push_back(w);
            end
        end
        while (st0.size() > 0 || st1.size() > 0) begin
            pick1 = (st1.size() > 0) && (st0.size() == 0 || !exp_last);
            do begin
                if (pick1) w = st1.pop_front();
                else       w = st0.pop_front();
                exp_q.push_back(w);
            end while (!w[16] && ((pick1 ? st1.size() : st0.size()) > 0));
            exp_last = pick1;
        end
        hold1 = -1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 2000) begin
            @(negedge pcie_clk);
            #2;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge pcie_clk);
        #2;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant == 2'b00 && n < 100) begin
            @(negedge pcie_clk);
            #2;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL grant_timeout actual=%0b required=nonzero", grant);
        end
    endtask

    task automatic check_counters();
        check("pkt_cnt0", 32'(pkt_cnt0), 32'(16'(exp_cnt0)));
        check("pkt_cnt1", 32'(pkt_cnt1), 32'(16'(exp_cnt1)));
        check("err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        int base;
        sys_rst = 1'b1;
        en      = 1'b1;
        err_clr = 1'b0;
        repeat (3) @(posedge pcie_clk);
        #2;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_wr_en", 32'(mst_wr_en), 32'd0);
        check("rst_mst_din", 32'(mst_din), 32'd0);
        check_counters();
        sys_rst = 1'b0;

        // Single 3-word packet on s0 with exact latency
        @(posedge pcie_clk);
        #2;
        st0.push_back(18'h200A1);
        st0.push_back(18'h000A2);
        st0.push_back(18'h100A3);
        commit();
        @(negedge pcie_clk); #2;
        check("lat_wr0", 32'(mst_wr_en), 32'd0);
        @(negedge pcie_clk); #2;
        check("lat_grant", 32'(grant), 32'b01);
        check("lat_wr1", 32'(mst_wr_en), 32'd0);
        check("lat_pop", 32'(s0_rd_en), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge pcie_clk); #2;
            check("burst_wr", 32'(mst_wr_en), 32'd1);
        end
        check("eof_grant_idle", 32'(grant), 32'd0);
        @(negedge pcie_clk); #2;
        check("after_wr", 32'(mst_wr_en), 32'd0);
        drain();
        check_counters();

        // Two packets on each source loaded together
        for (int i = 0; i < 2; i++) begin
            gen_pkt(0, $urandom_range(1, 4), 1'b0);
            gen_pkt(1, $urandom_range(1, 4), 1'b0);
        end
        @(posedge pcie_clk); #2;
        commit();
        drain();
        check_counters();

        // 16-word packet under random backpressure
        full_rand = 1'b1;
        base = wr_total;
        gen_pkt(0, 16, 1'b0);
        @(posedge pcie_clk); #2;
        commit();
        drain();
        full_rand = 1'b0;
        check("bp_write_count", 32'(wr_total - base), 32'd16);

        // s1 stalls mid-packet while s0 waits
        gen_pkt(1, 4, 1'b0);
        gen_pkt(0, 3, 1'b0);
        hold1 = 2;
        @(posedge pcie_clk); #2;
        commit();
        for (int i = 0; i < 10; i++) begin
            @(negedge pcie_clk); #2;
            check("stall_no_s0_pop", 32'(s0_rd_en), 32'd0);
        end
        @(posedge pcie_clk); #2;
        while (h1.size() > 0) q1.push_back(h1.pop_front());
        drain();
        check_counters();

        // Missing SOF, err_clr, and en dropped mid-packet
        gen_pkt(0, 3, 1'b1);
        @(posedge pcie_clk); #2;
        commit();
        wait_grant();
        en = 1'b0;
        gen_pkt(1, 2, 1'b0);
        commit();
        for (int i = 0; i < 20 && exp_q.size() > 2; i++) begin
            @(negedge pcie_clk); #2;
        end
        check("en_off_pkt_done", 32'(exp_q.size()), 32'd2);
        for (int i = 0; i < 8; i++) begin
            @(negedge pcie_clk); #2;
            check("en_off_grant", 32'(grant), 32'd0);
        end
        check("err_missing_sof", 32'(err), 32'(exp_err));
        @(posedge pcie_clk); #2;
        err_clr = 1'b1;
        @(posedge pcie_clk); #2;
        err_clr = 1'b0;
        exp_err = 2'b00;
        check("err_cleared", 32'(err), 32'd0);
        en = 1'b1;
        drain();
        check_counters();

        // Randomised rounds
        for (int r = 0; r < 6; r++) begin
            for (int p = $urandom_range(0, 3); p > 0; p--) gen_pkt(0, $urandom_range(1, 5), 1'b0);
            for (int p = $urandom_range(0, 3); p > 0; p--) gen_pkt(1, $urandom_range(1, 5), 1'b0);
            full_rand = 1'($urandom_range(0, 1));
            @(posedge pcie_clk); #2;
            commit();
            drain();
            full_rand = 1'b0;
            check_counters();
        end

        // Asynchronous reset mid-packet
        base = wr_total;
        gen_pkt(0, 8, 1'b0);
        @(posedge pcie_clk); #2;
        commit();
        for (int i = 0; i < 50 && wr_total < base + 2; i++) begin
            @(negedge pcie_clk); #2;
        end
        @(negedge pcie_clk);
        #3;
        sys_rst = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_wr_en", 32'(mst_wr_en), 32'd0);
        check("arst_rd_en", 32'({s1_rd_en, s0_rd_en}), 32'd0);
        check("arst_mst_din", 32'(mst_din), 32'd0);
        q0.delete();
        q1.delete();
        h1.delete();
        exp_q.delete();
        exp_last = 1'b1;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        exp_err  = 2'b00;
        check_counters();
        @(posedge pcie_clk); #2;
        sys_rst = 1'b0;
        gen_pkt(1, 3, 1'b0);
        gen_pkt(0, 3, 1'b0);
        @(posedge pcie_clk); #2;
        commit();
        wait_grant();
        check("post_rst_grant_s0", 32'(grant), 32'b01);
        drain();
        check_counters();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
